// File: rtl/gtech_pad_oe_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gtech_pad_oe_arbiter_if : requester/pad-bus bundle for the OE arbiter. Rev 1.0
// ----------------------------------------------------------------------------
interface gtech_pad_oe_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       gnt;
  logic                   oe;
  logic [WIDTH-1:0]       data_out;
  logic                   bus_busy;

  modport master (output req, data_in, input gnt, oe, data_out, bus_busy);
  modport slave  (input req, data_in, output gnt, oe, data_out, bus_busy);
endinterface
`default_nettype wire

// File: rtl/gtech_pad_oe_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gtech_pad_oe_arbiter : round-robin owner arbiter and OE sequencer for a shared
// tristate pad bus, with fixed turnaround between owners.            Rev 1.0
// ----------------------------------------------------------------------------
module gtech_pad_oe_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 16,
  parameter int TURN_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gtech_pad_oe_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [7:0]      burst, burst_nxt;
  logic [3:0]      turn, turn_nxt;
  logic [N_REQ-1:0] gnt_r, gnt_nxt;
  logic            oe_r;
  logic            busy_r;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     cand;

  // Rotating search starting at ptr; first requester found wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ))
        cand = cand - (IW+1)'(N_REQ);
      if (!win_vld && bus.req[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    burst_nxt = burst;
    turn_nxt  = turn;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = DRIVE;
          owner_nxt = win_idx;
          ptr_nxt   = (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
          burst_nxt = '0;
        end
      end
      DRIVE: begin
        if (!bus.req[owner] || burst == 8'(MAX_BURST-1)) begin
          state_nxt = TURN;
          turn_nxt  = '0;
        end else begin
          burst_nxt = burst + 8'd1;
        end
      end
      TURN: begin
        if (turn == 4'(TURN_CYC-1)) begin
          if (win_vld) begin
            state_nxt = DRIVE;
            owner_nxt = win_idx;
            ptr_nxt   = (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
            burst_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          turn_nxt = turn + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is decoded from the next owner so GNT/OE are true registers.
  for (genvar g = 0; g < N_REQ; g++) begin : g_gnt
    assign gnt_nxt[g] = (state_nxt == DRIVE) && (owner_nxt == IW'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      owner  <= '0;
      ptr    <= '0;
      burst  <= '0;
      turn   <= '0;
      gnt_r  <= '0;
      oe_r   <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      ptr    <= ptr_nxt;
      burst  <= burst_nxt;
      turn   <= turn_nxt;
      gnt_r  <= gnt_nxt;
      oe_r   <= (state_nxt == DRIVE);
      busy_r <= (state_nxt != IDLE);
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.oe       = oe_r;
  assign bus.bus_busy = busy_r;
  assign bus.data_out = oe_r ? bus.data_in[owner*WIDTH +: WIDTH] : '0;

endmodule
`default_nettype wire

// File: tb/tb_gtech_pad_oe_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gtech_pad_oe_arbiter : random + directed bench against a count-down model.
// ----------------------------------------------------------------------------
module tb_gtech_pad_oe_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 16;
  localparam int TC = 2;

  logic clk;
  logic rst_n;

  gtech_pad_oe_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  gtech_pad_oe_arbiter #(
    .N_REQ(N), .WIDTH(W), .MAX_BURST(MB), .TURN_CYC(TC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: who owns the bus, how many cycles it has owned, idle cycles left.
  int own  = -1;
  int held = 0;
  int gap  = 0;
  int ptr  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    own = -1; held = 0; gap = 0; ptr = 0;
  endfunction

  function automatic void model_arb(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (r[i]) begin
        own  = i;
        held = 1;
        ptr  = (i + 1) % N;
        return;
      end
    end
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    if (own >= 0) begin
      if (!r[own] || held == MB) begin
        own = -1;
        gap = TC;
      end else begin
        held++;
      end
    end else if (gap > 0) begin
      gap--;
      if (gap == 0) model_arb(r);
    end else begin
      model_arb(r);
    end
  endfunction

  task automatic check_outputs();
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    eg = '0;
    ed = '0;
    if (own >= 0) begin
      eg[own] = 1'b1;
      ed = bus.data_in[own*W +: W];
    end
    chk("gnt",      64'(bus.gnt),      64'(eg));
    chk("oe",       64'(bus.oe),       64'(own >= 0));
    chk("bus_busy", 64'(bus.bus_busy), 64'(own >= 0 || gap > 0));
    chk("data_out", 64'(bus.data_out), 64'(ed));
    chk("oe_eq_or_gnt", 64'(bus.oe), 64'(|bus.gnt));
    chk("gnt_onehot0",  64'($countones(bus.gnt) <= 1), 64'(1));
  endtask

  // One clock: model sees the REQ present at the edge, then new stimulus is applied.
  task automatic cycle(input logic [N-1:0] nreq);
    @(posedge clk);
    model_step(bus.req);
    #1;
    bus.req     = nreq;
    bus.data_in = $urandom();
    #1;
    check_outputs();
  endtask

  task automatic run_until_owner(input logic [N-1:0] r, input int who, input string tag);
    for (int c = 0; c < 60 && own != who; c++) cycle(r);
    chk(tag, 64'(bus.gnt), 64'(1 << who));
  endtask

  initial begin
    logic [N-1:0] rq;
    rst_n       = 1'b0;
    bus.req     = '0;
    bus.data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt",  64'(bus.gnt),      64'(0));
    chk("rst_oe",   64'(bus.oe),       64'(0));
    chk("rst_busy", 64'(bus.bus_busy), 64'(0));
    chk("rst_dout", 64'(bus.data_out), 64'(0));
    rst_n = 1'b1;

    // Single short request
    repeat (3) cycle(4'b0001);
    repeat (8) cycle(4'b0000);

    // Burst limit with one persistent requester
    repeat (40) cycle(4'b0010);
    repeat (6)  cycle(4'b0000);

    // Everyone requesting: round-robin rotation
    repeat (90) cycle(4'b1111);
    repeat (6)  cycle(4'b0000);

    // Owner 2 releases in the same cycle requester 0 arrives
    run_until_owner(4'b0100, 2, "own2_reached");
    repeat (3) cycle(4'b0100);
    repeat (8) cycle(4'b0001);
    repeat (20) cycle(4'b0000);

    // Non-owner toggling during a burst is ignored
    run_until_owner(4'b0010, 1, "own1_reached");
    for (int c = 0; c < 6; c++) cycle({c[0], 3'b010});
    chk("nonowner_ignored", 64'(bus.gnt), 64'(4'b0010));
    repeat (8) cycle(4'b1000);
    repeat (20) cycle(4'b0000);

    // Random request traffic
    rq = '0;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
      cycle(rq);
    end
    repeat (20) cycle(4'b0000);

    // Asynchronous reset in the middle of an owner-3 burst
    run_until_owner(4'b1000, 3, "own3_reached");
    repeat (3) cycle(4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt",  64'(bus.gnt),      64'(0));
    chk("async_oe",   64'(bus.oe),       64'(0));
    chk("async_dout", 64'(bus.data_out), 64'(0));
    chk("async_busy", 64'(bus.bus_busy), 64'(0));
    model_reset();
    bus.req = 4'b1001;
    @(posedge clk);
    #2;
    chk("held_rst_gnt", 64'(bus.gnt), 64'(0));
    rst_n = 1'b1;
    cycle(4'b1001);
    chk("post_rst_owner0", 64'(bus.gnt), 64'(4'b0001));
    repeat (40) cycle(4'b1001);
    repeat (10) cycle(4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
`default_nettype wire
